// File: rtl/exception_cp0_if.sv
// Signal bundle between the pipeline (exception detector, decode, PC mux) and
// the CP0 exception state holder.
interface exception_cp0_if;
  logic        exc_valid;
  logic        exc_cause;
  logic [31:0] exc_epc;
  logic        eret;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc_q;
  logic        status_exl;
  logic [1:0]  dbg_state;

  // Handshake: exc_valid and eret are level requests sampled on every rising edge.
  // Neither has a ready; a request that arrives in a state that cannot take it is
  // dropped, and the requester re-raises it if it still applies.
  // pc_redirect is a one-cycle pulse with pc_target valid only while it is high.
  modport master (
    output exc_valid, exc_cause, exc_epc, eret, rd_sel,
    input  rd_data, pc_redirect, pc_target, epc_q, status_exl, dbg_state
  );
  modport slave (
    input  exc_valid, exc_cause, exc_epc, eret, rd_sel,
    output rd_data, pc_redirect, pc_target, epc_q, status_exl, dbg_state
  );
endinterface

// File: rtl/exception_cp0.sv
// CP0 exception state: latches EPC/Cause/Status, pulses a PC redirect to the
// handler and back on ERET. Optional exception counter enabled by EXC_COUNT_EN.
module exception_cp0 #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
  parameter logic [4:0]  EXC_OV       = 5'd12,
  parameter logic [4:0]  EXC_RI       = 5'd10
) (
  input  logic           clk,
  input  logic           rst_n,
  exception_cp0_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_HANDLER  = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic [31:0] r_epc;
  logic [4:0]  r_exc_code;
  logic        r_exl;
  logic [31:0] w_count_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // EXL masks new exceptions, so only IDLE can accept one.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.exc_valid) begin
          w_accept = 1'b1;
          w_next   = S_REDIRECT;
        end
      end
      S_REDIRECT: w_next = S_HANDLER;
      S_HANDLER:  if (bus.eret) w_next = S_RETURN;
      S_RETURN:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc      <= 32'h0;
      r_exc_code <= 5'd0;
      r_exl      <= 1'b0;
    end else if (w_accept) begin
      r_epc      <= bus.exc_epc;
      r_exc_code <= bus.exc_cause ? EXC_OV : EXC_RI;
      r_exl      <= 1'b1;
    end else if (r_state == S_RETURN) begin
      r_exl      <= 1'b0;
    end
  end

`ifdef EXC_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_count <= 16'h0;
    else if (w_accept && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
  end

  assign w_count_rd = {16'h0, r_count};
`else
  assign w_count_rd = 32'h0;
`endif

  // Moore outputs: the redirect pulse is purely a function of state, so an
  // asynchronous reset cuts it immediately.
  always_comb begin
    bus.pc_redirect = 1'b0;
    bus.pc_target   = 32'h0;
    case (r_state)
      S_REDIRECT: begin
        bus.pc_redirect = 1'b1;
        bus.pc_target   = HANDLER_ADDR;
      end
      S_RETURN: begin
        bus.pc_redirect = 1'b1;
        bus.pc_target   = r_epc;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.rd_data = 32'h0;
    case (bus.rd_sel)
      2'd0: bus.rd_data = r_epc;
      2'd1: bus.rd_data = {25'h0, r_exc_code, 2'b00};
      2'd2: bus.rd_data = {31'h0, r_exl};
      2'd3: bus.rd_data = w_count_rd;
      default: bus.rd_data = 32'h0;
    endcase
  end

  assign bus.epc_q      = r_epc;
  assign bus.status_exl = r_exl;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_exception_cp0.sv
// Self-checking bench for exception_cp0: reference model feeds an expected queue
// of post-edge outputs, plus combinational read-port checks after every cycle.
module tb_exception_cp0;

  localparam int W = 66; // {pc_redirect, status_exl, pc_target, epc_q}

  logic clk;
  logic rst_n;

  exception_cp0_if bus ();

  exception_cp0 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;

  // reference model (0 idle, 1 redirect, 2 handler, 3 return)
  int          m_state;
  logic [31:0] m_epc;
  logic [4:0]  m_code;
  logic        m_exl;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int sel);
    case (sel)
      0: return m_epc;
      1: return {25'h0, m_code, 2'b00};
      2: return {31'h0, m_exl};
`ifdef EXC_COUNT_EN
      3: return {16'h0, m_cnt};
`else
      3: return 32'h0;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_epc   = 32'h0;
    m_code  = 5'd0;
    m_exl   = 1'b0;
    m_cnt   = 16'h0;
  endtask

  // Advance the model across one rising edge and queue the outputs expected after it.
  task automatic model_edge(input logic v, input logic c, input logic [31:0] epc, input logic e);
    logic        redir;
    logic [31:0] tgt;
    case (m_state)
      0: if (v) begin
           m_epc  = epc;
           m_code = c ? 5'd12 : 5'd10;
           m_exl  = 1'b1;
           if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
           m_state = 1;
         end
      1: m_state = 2;
      2: if (e) m_state = 3;
      default: begin
        m_exl   = 1'b0;
        m_state = 0;
      end
    endcase
    redir = (m_state == 1) || (m_state == 3);
    tgt   = (m_state == 1) ? 32'h0000_0180 : (m_state == 3) ? m_epc : 32'h0;
    exp_q.push_back({redir, m_exl, tgt, m_epc});
  endtask

  task automatic check_reads(input string tag);
    for (int sel = 0; sel < 4; sel++) begin
      bus.rd_sel = sel[1:0];
      #1;
      check($sformatf("%s_rd%0d", tag, sel), bus.rd_data, model_read(sel));
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'h1, 32'h0);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_redirect"}, {31'h0, bus.pc_redirect}, {31'h0, exp[65]});
    check({tag, "_exl"},      {31'h0, bus.status_exl},  {31'h0, exp[64]});
    check({tag, "_target"},   bus.pc_target,            exp[63:32]);
    check({tag, "_epc_q"},    bus.epc_q,                exp[31:0]);
    check_reads(tag);
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic v, input logic c,
                      input logic [31:0] epc, input logic e);
    @(negedge clk);
    bus.exc_valid = v;
    bus.exc_cause = c;
    bus.exc_epc   = epc;
    bus.eret      = e;
    model_edge(v, c, epc, e);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_cause = 1'b0;
    bus.exc_epc   = 32'h0;
    bus.eret      = 1'b0;
    bus.rd_sel    = 2'd0;
    model_reset();

    #35;
    check("rst_redirect", {31'h0, bus.pc_redirect}, 32'h0);
    check("rst_target", bus.pc_target, 32'h0);
    check_reads("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // exception entry: overflow at 0x40
    step("entry", 1'b1, 1'b1, 32'h40, 1'b0);
    check("entry_cause_const", model_read(1), 32'h30);
    idle("handler");
    step("masked", 1'b1, 1'b0, 32'h99, 1'b0);
    step("eret", 1'b0, 1'b0, 32'h0, 1'b1);
    idle("after_ret");
    check("after_ret_exl", {31'h0, bus.status_exl}, 32'h0);

    step("eret_in_idle", 1'b0, 1'b0, 32'h0, 1'b1);

    // simultaneous requests
    step("entry2", 1'b1, 1'b1, 32'h40, 1'b0);
    idle("handler2");
    step("both_handler", 1'b1, 1'b0, 32'h99, 1'b1);
    check("both_handler_tgt", bus.pc_target, 32'h40);
    idle("idle2");
    step("both_idle", 1'b1, 1'b0, 32'h1234, 1'b1);
    bus.rd_sel = 2'd1;
    #1;
    check("both_idle_cause", bus.rd_data, 32'h28);

    // drops in REDIRECT and RETURN, then back-to-back accept
    step("drop_redirect", 1'b1, 1'b1, 32'h55, 1'b0);
    step("eret3", 1'b0, 1'b0, 32'h0, 1'b1);
    step("drop_return", 1'b1, 1'b1, 32'h66, 1'b0);
    step("b2b_accept", 1'b1, 1'b1, 32'h77, 1'b0);
    idle("b2b_handler");
    step("b2b_eret", 1'b0, 1'b0, 32'h0, 1'b1);
    check("b2b_ret_tgt", bus.pc_target, 32'h77);
    idle("b2b_idle");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'(($urandom_range(0, 2)) == 0), 1'($urandom_range(0, 1)),
           {$urandom_range(0, 32'h3FFF), 2'b00}, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset during the handler redirect pulse
    while (m_state != 0) idle("drain");
    step("pre_rst", 1'b1, 1'b0, 32'hABC0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_redirect", {31'h0, bus.pc_redirect}, 32'h0);
    check("async_target", bus.pc_target, 32'h0);
    model_reset();
    bus.exc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reads("post_rst");
    idle("post_rst_idle");
    idle("post_rst_idle2");

    // 3 accepted + 2 masked exceptions for the counter
    for (int k = 0; k < 3; k++) begin
      step("cnt_acc", 1'b1, 1'b1, 32'h100 + k, 1'b0);
      idle("cnt_h");
      if (k == 0) step("cnt_mask", 1'b1, 1'b0, 32'h200, 1'b0);
      if (k == 1) step("cnt_mask", 1'b1, 1'b0, 32'h204, 1'b0);
      step("cnt_eret", 1'b0, 1'b0, 32'h0, 1'b1);
      idle("cnt_idle");
    end
    bus.rd_sel = 2'd3;
    #1;
`ifdef EXC_COUNT_EN
    check("count_final", bus.rd_data, 32'h3);
`else
    check("count_final", bus.rd_data, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/exception_cp0.md
Name: exception_cp0

Overview:
- Coprocessor-0 style exception state holder, directly downstream of the pipeline exception detector.
- Consumes the detector's exception-select strobe, cause bit and computed EPC, and latches them into architectural EPC/Cause/Status registers.
- Drives a one-cycle PC redirect to the handler vector, then a one-cycle redirect back to EPC on ERET.
- Provides a combinational MFC0-style read port for the decode stage.

Parameters:
HANDLER_ADDR, 32'h0000_0180, PC target on exception entry
EXC_OV, 5'd12, ExcCode written for arithmetic overflow
EXC_RI, 5'd10, ExcCode written for undefined/reserved instruction

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
exc_valid  input  1  exception request from detector (its EPC-select strobe), level, sampled at posedge
exc_cause  input  1  1 = overflow, 0 = undefined instruction; valid with exc_valid
exc_epc  input  32  faulting PC from detector; valid with exc_valid
eret  input  1  exception-return request from decode, sampled at posedge
rd_sel  input  2  read select: 0 EPC, 1 Cause, 2 Status, 3 counter
rd_data  output  32  combinational read data per rd_sel
pc_redirect  output  1  PC mux override, high for exactly one cycle per redirect
pc_target  output  32  redirect address; 0 when pc_redirect low
epc_q  output  32  current EPC register
status_exl  output  1  exception-level bit; 1 while exception is being handled

Behaviour:
- Interface fixed: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values, applied immediately on rst_n low:
  - state IDLE; EPC 0; Cause 0; EXL 0
  - pc_redirect 0; pc_target 0; counter 0
- Registers:
  - Cause = {BD(bit31)=0, 24'b0, ExcCode[6:2], 2'b0}.
  - Status = {31'b0, EXL}.
- FSM states, with outputs decoded from state (Moore):
  - IDLE:
    - exc_valid=1 at posedge: EPC<=exc_epc; ExcCode<=exc_cause ? EXC_OV : EXC_RI; EXL<=1; next REDIRECT.
    - eret in IDLE is ignored; no redirect.
  - REDIRECT: pc_redirect=1, pc_target=HANDLER_ADDR; unconditionally next HANDLER.
  - HANDLER:
    - eret=1: next RETURN.
    - exc_valid is ignored (masked by EXL); EPC/Cause unchanged.
  - RETURN: pc_redirect=1, pc_target=EPC; EXL<=0 on exit; next IDLE.
- Latency:
  - exception accepted at edge N; redirect visible during cycle N+1.
  - eret sampled at edge M; return redirect visible during cycle M+1.
- Simultaneous events:
  - exc_valid and eret together in IDLE: exception taken, eret dropped.
  - exc_valid and eret together in HANDLER: eret taken, exception dropped.
  - exc_valid in REDIRECT/RETURN: dropped.
- Back-to-back: exc_valid high in the cycle after RETURN (state IDLE) is accepted normally; EPC is overwritten.
- rd_data: pure combinational mux of the registers, no read side effects. Counter sel reads 0 when the optional feature is absent.
- Reset mid-operation: any state returns to IDLE asynchronously. An in-flight redirect pulse is cut short; no redirect fires after release.

Optional Feature:
- Macro EXC_COUNT_EN.
- Defined:
  - 16-bit counter increments on each accepted exception (IDLE -> REDIRECT only).
  - Saturates at 16'hFFFF; dropped requests do not count.
  - rd_sel=3 returns {16'b0, count}.
- Undefined: no counter logic; rd_sel=3 returns 32'h0.

Test Plan:
- Reset release, exc_valid=1, exc_cause=1, exc_epc=32'h0000_0040 -> next cycle pc_redirect=1, pc_target=32'h180, status_exl=1; rd_sel=1 reads 32'h0000_0030; rd_sel=0 reads 32'h40.
- From HANDLER, eret pulse -> next cycle pc_redirect=1, pc_target=32'h40; following cycle pc_redirect=0, status_exl=0, state IDLE.
- In HANDLER, exc_valid=1 with exc_epc=32'h99 and exc_cause=0 -> no redirect; EPC still 32'h40; Cause still 32'h30.
- In HANDLER, exc_valid and eret both high -> return redirect to 32'h40. In IDLE, both high -> handler redirect, EPC from exc_epc, Cause 32'h28 when exc_cause=0.
- rst_n low asynchronously during REDIRECT cycle -> pc_redirect drops without a clock edge; all reads 0 after release.
- With EXC_COUNT_EN, 3 accepted exceptions plus 2 masked ones -> rd_sel=3 reads 32'h3. Without the macro -> rd_sel=3 reads 32'h0.
